// File: rtl/imem_loader_server_pkg.sv
// Shared types, constants and helpers for the instruction-memory loader/server.
// IMEM_PARITY_EN (when defined) enables the parity helper's use in the array path.
package imem_pkg;

    localparam int          IMEM_ADDR_W = 12;
    localparam int          IMEM_DATA_W = 32;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Even-parity bit: the stored word plus this bit always has an even number of ones.
    function automatic logic parity32(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_loader_server_if.sv
// Fetch-side and loader-side signals of the instruction memory, grouped as one bus.
// IMEM_PARITY_EN adds the parity_err output to the bus.
interface imem_loader_server_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] insn_address;
    logic [DATA_W-1:0] q_imem;
    logic              stall;
    logic              load_start;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_done;
    logic              load_err;
`ifdef IMEM_PARITY_EN
    logic              parity_err;
`endif

    modport slave (
        input  insn_address, load_start, load_valid, load_data, load_last,
        output q_imem, stall, load_ready, load_done, load_err
`ifdef IMEM_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output insn_address, load_start, load_valid, load_data, load_last,
        input  q_imem, stall, load_ready, load_done, load_err
`ifdef IMEM_PARITY_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/imem_loader_server_array.sv
// Single-clock instruction store: one synchronous write port, one synchronous read port.
// Width is set by the parent so the parity bit (IMEM_PARITY_EN) can ride along.
module imem_array #(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto block RAM; the program survives a reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_loader_server.sv
// Instruction-memory server: a loader fills the array, then fetch reads it with 1-cycle latency.
// Optional IMEM_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module imem_loader_server
    import imem_pkg::*;
#(
    parameter int                ADDR_W = IMEM_ADDR_W,
    parameter int                DATA_W = IMEM_DATA_W,
    parameter logic [DATA_W-1:0] NOP    = NOP_WORD
) (
    input  logic                 clock,
    input  logic                 reset,
    imem_loader_server_if.slave  bus
);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              load_done_q;
    logic              load_err_q;
    logic              run_q;
    logic              accept;
    logic [MEM_W-1:0]  wdata;
    logic [MEM_W-1:0]  rdata;

    // load_start in the same cycle as a beat wins and the beat is discarded.
    assign accept = (state == LOAD) && bus.load_valid && !bus.load_start;

`ifdef IMEM_PARITY_EN
    assign wdata = {parity32(bus.load_data), bus.load_data};
`else
    assign wdata = bus.load_data;
`endif

    imem_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_array (
        .clock (clock),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (bus.insn_address),
        .rdata (rdata)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.load_start) state_nxt = LOAD;
            LOAD: begin
                if (bus.load_start)                  state_nxt = LOAD;
                else if (accept && bus.load_last)    state_nxt = RUN;
            end
            RUN:  if (bus.load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= (state == RUN);

            if (bus.load_start) begin
                wr_ptr <= '0;
            end else if (accept) begin
                wr_ptr <= bus.load_last ? '0 : wr_ptr + 1'b1;
            end

            // Reprogramming from RUN invalidates the previous program's status.
            if (state == RUN && bus.load_start) begin
                load_done_q <= 1'b0;
                load_err_q  <= 1'b0;
            end else if (accept) begin
                if (bus.load_last) begin
                    load_done_q <= 1'b1;
                end else if (wr_ptr == '1) begin
                    load_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.stall      = (state != RUN);
    assign bus.load_ready = (state == LOAD);
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

    // run_q marks that rdata was fetched during RUN; anything else is replaced by NOP.
`ifdef IMEM_PARITY_EN
    logic perr;
    assign perr           = run_q && (rdata[DATA_W] != parity32(rdata[DATA_W-1:0]));
    assign bus.parity_err = perr;
    assign bus.q_imem     = (run_q && !perr) ? rdata[DATA_W-1:0] : NOP;
`else
    assign bus.q_imem     = run_q ? rdata : NOP;
`endif

endmodule

// File: tb/tb_imem_loader_server.sv
// Scoreboarded bench for imem_loader_server: a 12-bit instance for the main flows and a
// 2-bit-address instance for pointer wrap. Parity flip test runs when IMEM_PARITY_EN is defined.
module tb_imem_loader_server;
    import imem_pkg::*;

    localparam int AW_A = 12;
    localparam int AW_B = 2;
    localparam int DW   = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_loader_server_if #(.ADDR_W(AW_A), .DATA_W(DW)) bus_a ();
    imem_loader_server_if #(.ADDR_W(AW_B), .DATA_W(DW)) bus_b ();

    imem_loader_server #(.ADDR_W(AW_A), .DATA_W(DW)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    imem_loader_server #(.ADDR_W(AW_B), .DATA_W(DW)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    logic [31:0] exp_q   [$];
    int          wr_a = 0;
    int          wr_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_a();
        bus_a.load_start = 1'b1;
        tick();
        bus_a.load_start = 1'b0;
        wr_a = 0;
    endtask

    // Present one beat, hold it until accepted, then idle for `gap` cycles.
    task automatic send_a(input logic [31:0] w, input logic is_last, input int gap);
        int n;
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = w;
        bus_a.load_last  = is_last;
        n = 0;
        while (bus_a.load_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("send_ready_a", {31'b0, bus_a.load_ready}, 32'd1);
        tick();
        model_a[wr_a] = w;
        wr_a = is_last ? 0 : wr_a + 1;
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
        repeat (gap) begin
            bus_a.load_data = 32'hdead_beef;
            tick();
        end
    endtask

    task automatic read_a(input logic [AW_A-1:0] addr);
        bus_a.insn_address = addr;
        exp_q.push_back(model_a[int'(addr)]);
        tick();
        check($sformatf("rd_a[%0d]", addr), bus_a.q_imem, exp_q.pop_front());
    endtask

    task automatic read_b(input logic [AW_B-1:0] addr);
        bus_b.insn_address = addr;
        exp_q.push_back(model_b[int'(addr)]);
        tick();
        check($sformatf("rd_b[%0d]", addr), bus_b.q_imem, exp_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.insn_address = '0; bus_a.load_start = 1'b0; bus_a.load_valid = 1'b0;
        bus_a.load_data    = '0; bus_a.load_last  = 1'b0;
        bus_b.insn_address = '0; bus_b.load_start = 1'b0; bus_b.load_valid = 1'b0;
        bus_b.load_data    = '0; bus_b.load_last  = 1'b0;

        // 1. reset state
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_stall",  {31'b0, bus_a.stall},      32'd1);
        check("rst_ready",  {31'b0, bus_a.load_ready}, 32'd0);
        check("rst_q",      bus_a.q_imem,              NOP_WORD);
        check("rst_done",   {31'b0, bus_a.load_done},  32'd0);
        check("rst_err",    {31'b0, bus_a.load_err},   32'd0);

        // 2. basic load of four words, then reads
        start_a();
        check("load_ready_a", {31'b0, bus_a.load_ready}, 32'd1);
        check("load_stall_a", {31'b0, bus_a.stall},      32'd1);
        send_a(32'h11, 1'b0, 0);
        send_a(32'h22, 1'b0, 0);
        send_a(32'h33, 1'b0, 0);
        send_a(32'h44, 1'b1, 0);
        check("run_stall",   {31'b0, bus_a.stall},      32'd0);
        check("run_done",    {31'b0, bus_a.load_done},  32'd1);
        check("run_ready",   {31'b0, bus_a.load_ready}, 32'd0);
        check("run_first_q", bus_a.q_imem,              NOP_WORD);
        read_a(12'd2);
        read_a(12'd0);
        read_a(12'd3);
        read_a(12'd1);

        // 3. reprogram from RUN; a beat coinciding with load_start is dropped; gapped valid
        bus_a.load_start = 1'b1;
        check("stall_before_edge", {31'b0, bus_a.stall}, 32'd0);
        tick();
        check("stall_after_start", {31'b0, bus_a.stall},     32'd1);
        check("done_cleared",      {31'b0, bus_a.load_done}, 32'd0);
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 32'h0000_0bad;
        tick();
        bus_a.load_start = 1'b0;
        bus_a.load_valid = 1'b0;
        wr_a = 0;
        send_a(32'ha1, 1'b0, 1);
        send_a(32'ha2, 1'b0, 1);
        send_a(32'ha3, 1'b1, 0);
        check("gap_done", {31'b0, bus_a.load_done}, 32'd1);
        read_a(12'd0);
        read_a(12'd1);
        read_a(12'd2);

        // 4. wrap on the 4-word instance
        bus_b.load_start = 1'b1;
        tick();
        bus_b.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_b.load_valid = 1'b1;
            bus_b.load_data  = 32'h51 + i;
            bus_b.load_last  = (i == 4);
            check("b_ready", {31'b0, bus_b.load_ready}, 32'd1);
            tick();
            model_b[wr_b] = 32'h51 + i;
            wr_b = (i == 4) ? 0 : (wr_b + 1) % 4;
            if (i == 2) check("b_err_early", {31'b0, bus_b.load_err}, 32'd0);
            if (i == 3) begin
                check("b_err_wrap",  {31'b0, bus_b.load_err},  32'd1);
                check("b_still_ld",  {31'b0, bus_b.stall},     32'd1);
                check("b_done_wrap", {31'b0, bus_b.load_done}, 32'd0);
            end
        end
        bus_b.load_valid = 1'b0;
        bus_b.load_last  = 1'b0;
        check("b_done", {31'b0, bus_b.load_done}, 32'd1);
        check("b_err",  {31'b0, bus_b.load_err},  32'd1);
        check("b_run",  {31'b0, bus_b.stall},     32'd0);
        read_b(2'd0);
        read_b(2'd1);

        // 5. reset in the middle of a load, then a full reload
        start_a();
        send_a(32'h61, 1'b0, 0);
        send_a(32'h62, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_stall", {31'b0, bus_a.stall},      32'd1);
        check("mid_rst_ready", {31'b0, bus_a.load_ready}, 32'd0);
        check("mid_rst_done",  {31'b0, bus_a.load_done},  32'd0);
        check("mid_rst_err",   {31'b0, bus_a.load_err},   32'd0);
        check("mid_rst_q",     bus_a.q_imem,              NOP_WORD);
        check("mid_rst_b_err", {31'b0, bus_b.load_err},   32'd0);
        check("mid_rst_b_q",   bus_b.q_imem,              NOP_WORD);
        tick();
        tick();
        reset = 1'b1;
        tick();
        start_a();
        send_a(32'h71, 1'b0, 0);
        send_a(32'h72, 1'b0, 0);
        send_a(32'h73, 1'b0, 0);
        send_a(32'h74, 1'b1, 0);
        read_a(12'd0);
        read_a(12'd1);
        read_a(12'd2);
        read_a(12'd3);

`ifdef IMEM_PARITY_EN
        // 6. corrupt stored parity of word 1
        dut_a.u_array.mem[1][DW] = ~dut_a.u_array.mem[1][DW];
        bus_a.insn_address = 12'd1;
        tick();
        check("par_err_hit", {31'b0, bus_a.parity_err}, 32'd1);
        check("par_q_nop",   bus_a.q_imem,              NOP_WORD);
        bus_a.insn_address = 12'd0;
        tick();
        check("par_err_pulse", {31'b0, bus_a.parity_err}, 32'd0);
        check("par_q_ok",      bus_a.q_imem,              32'h71);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
